i2c_master_burst_datapath: RTL and testbench
============================================

Name: i2c_master_burst_datapath

Overview:
- Parametrised successor to the single-byte I2C master datapath.
- Owns its own transfer FSM and moves 1..MAX_BYTES data bytes per transaction, read or write, to one 7-bit slave address.
- Checks slave ACKs, generates master ACK/NACK on reads, and aborts to STOP on NACK.
- Sits between the register/command layer and the SCL generator; it drives SDA_out and requests SCL via i2c_scl_en.

Parameters:
- MAX_BYTES, 4, maximum bytes per transaction (>=1).
- LEN_W, $clog2(MAX_BYTES+1), width of len and byte counters.

Ports:
- i2c_scl_in  in  1  bit clock; all state updates on its falling edge.
- resetN  in  1  synchronous active-low reset, sampled on the falling edge of i2c_scl_in.
- start  in  1  transaction request, sampled in IDLE only.
- rw  in  1  0=write, 1=read.
- address  in  7  slave address.
- len  in  LEN_W  byte count, 1..MAX_BYTES.
- wdata  in  8*MAX_BYTES  write bytes; byte i = wdata[8i+7:8i]; byte 0 sent first, MSB first.
- SDA_in  in  1  sampled bus SDA.
- SDA_out  out  1  SDA drive (1 = released/high).
- i2c_scl_en  out  1  SCL generator enable; equals busy.
- busy  out  1  transaction in progress (state != IDLE).
- done  out  1  one-cycle pulse at end of transaction.
- nack  out  1  last transaction aborted by a slave NACK; held until the next accepted start.
- rdata  out  8*MAX_BYTES  read bytes, same packing as wdata.
- byte_cnt  out  LEN_W  bytes completed (ACKed write bytes, or received read bytes).

Behaviour:
- Reset (resetN=0 at an edge): state=IDLE, SDA_out=1, done=0, nack=0, busy=0, rdata=0, byte_cnt=0, internal counters cleared.
  - Reset mid-transfer aborts immediately with SDA released; no STOP is generated.
- Register update rule: every output is registered. Each bullet below is the action taken at the edge while in that state.
- IDLE: SDA_out<=1, done<=0.
  - start=1 with 1<=len<=MAX_BYTES: latch {address,rw}, len, wdata; clear nack, byte_cnt and byte index; go to START.
  - start with len=0 or len>MAX_BYTES: ignored.
- START: SDA_out<=0; bit count<=7; go to ADDRESS.
- ADDRESS (count k): SDA_out<=addr_byte[k]; k decrements; at k==0 go to ADDR_ACK.
- ADDR_ACK: SDA_out<=1 (release); go to ADDR_CHK.
- ADDR_CHK: sample SDA_in.
  - SDA_in=1: nack<=1, SDA_out<=0, go to STOP.
  - ACK and write: SDA_out<=byte0[7], count<=6, go to WRITE_DATA.
  - ACK and read: SDA_out<=1, count<=7, go to READ_DATA.
- WRITE_DATA (count k): SDA_out<=byte[idx][k]; at k==0 go to WR_ACK.
- WR_ACK: SDA_out<=1; go to WR_CHK.
- WR_CHK: sample SDA_in.
  - NACK: nack<=1, SDA_out<=0, go to STOP; byte_cnt is not incremented.
  - ACK: byte_cnt++.
    - Last byte: SDA_out<=0, go to STOP.
    - Otherwise: idx++, SDA_out<=byte[idx+1][7], count<=6, go to WRITE_DATA.
- READ_DATA (count k): rdata[8*idx+k]<=SDA_in; SDA_out<=1.
  - At k==0: SDA_out<=(last ? 1 : 0) (master NACK on last byte, ACK otherwise); byte_cnt++; go to RD_ACK.
- RD_ACK:
  - Last byte: SDA_out<=0, go to STOP.
  - Otherwise: SDA_out<=1, idx++, count<=7, go to READ_DATA.
- STOP: SDA_out<=1; done<=1; go to IDLE. done is high for exactly one cycle.
- Latency: accept edge (IDLE) to done-set edge = 12+9*len edges on a fully ACKed transfer; 12 edges on an address NACK.
- rdata bytes at index >= len keep the values from the previous transaction; they are not cleared per transaction.
- start while busy: ignored.
- start at the edge where STOP completes: not accepted (state is STOP, not IDLE); it is accepted on the following edge if still asserted.
- Address and data changes while busy: no effect; values are latched at accept.

Test Plan:
- Reset: resetN=0 for 2 edges mid-ADDRESS -> SDA_out=1, busy=0, done=0, state IDLE, no further SDA toggles.
- Single write: address=0x50, rw=0, len=1, wdata[7:0]=0xA5, slave ACKs.
  - SDA_out serial: 0, then 1010000 0 (address + rw), release, then 10100101, release, 0, 1.
  - done pulses 21 edges after accept; nack=0; byte_cnt=1.
- Burst read: address=0x3C, rw=1, len=3, slave drives 0x11, 0x22, 0x33.
  - rdata[23:0]=0x332211.
  - Master ACK=0 after bytes 0 and 1, NACK=1 after byte 2.
  - done 39 edges after accept; byte_cnt=3.
- Address NACK: SDA_in=1 in the ADDR_CHK slot -> nack=1, STOP issued, done 12 edges after accept, byte_cnt=0, no data bits driven.
- Data NACK: write len=4, slave NACKs byte 1 -> byte_cnt=1, nack=1, STOP immediately, done 30 edges after accept.
- Ignore rules: start with len=0 -> busy stays 0. start pulse during a busy write -> no effect on the running transfer. Next start after done with len=MAX_BYTES -> accepted; nack cleared.

Source files
------------

// File: rtl/i2c_master_burst_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : i2c_master_burst_datapath                                  |
// | Description : I2C master transfer engine moving 1..MAX_BYTES bytes per   |
// |               transaction (read or write) to one 7-bit slave address.    |
// |               Checks slave ACKs, generates master ACK/NACK on reads and  |
// |               aborts to STOP on a slave NACK. All state advances on the  |
// |               falling edge of the bit clock i2c_scl_in.                  |
// | Ports       : i2c_scl_in  bit clock (falling edge active)                |
// |               resetN      synchronous active-low reset                   |
// |               start/rw/address/len/wdata  transaction request            |
// |               SDA_in      sampled bus SDA                                |
// |               SDA_out     SDA drive, 1 = released                        |
// |               i2c_scl_en  SCL generator enable (same as busy)            |
// |               busy/done/nack  status; rdata/byte_cnt  results            |
// | Revision    : 1.0  initial burst-capable release                         |
// +--------------------------------------------------------------------------+
module i2c_master_burst_datapath #(
  parameter int MAX_BYTES = 4,
  parameter int LEN_W     = $clog2(MAX_BYTES + 1)
) (
  input  logic                   i2c_scl_in,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   rw,
  input  logic [6:0]             address,
  input  logic [LEN_W-1:0]       len,
  input  logic [8*MAX_BYTES-1:0] wdata,
  input  logic                   SDA_in,
  output logic                   SDA_out,
  output logic                   i2c_scl_en,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic [8*MAX_BYTES-1:0] rdata,
  output logic [LEN_W-1:0]       byte_cnt
);

  localparam int                DATA_W   = 8 * MAX_BYTES;
  localparam int                POS_W    = LEN_W + 3;
  localparam logic [LEN_W-1:0]  MAX_LEN  = LEN_W'(MAX_BYTES);
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  localparam logic [3:0] ST_IDLE       = 4'd0;
  localparam logic [3:0] ST_START      = 4'd1;
  localparam logic [3:0] ST_ADDRESS    = 4'd2;
  localparam logic [3:0] ST_ADDR_ACK   = 4'd3;
  localparam logic [3:0] ST_ADDR_CHK   = 4'd4;
  localparam logic [3:0] ST_WRITE_DATA = 4'd5;
  localparam logic [3:0] ST_WR_ACK     = 4'd6;
  localparam logic [3:0] ST_WR_CHK     = 4'd7;
  localparam logic [3:0] ST_READ_DATA  = 4'd8;
  localparam logic [3:0] ST_RD_ACK     = 4'd9;
  localparam logic [3:0] ST_STOP       = 4'd10;

  // ---------------------------------------------------------------------------
  // State registers and their next-state values
  // ---------------------------------------------------------------------------
  logic [3:0]        state_q,    state_d;
  logic [7:0]        addr_q,     addr_d;      // {address, rw}
  logic [LEN_W-1:0]  len_q,      len_d;
  logic [DATA_W-1:0] wdata_q,    wdata_d;
  logic [LEN_W-1:0]  idx_q,      idx_d;       // current byte index
  logic [2:0]        bit_q,      bit_d;       // current bit within byte
  logic              sda_q,      sda_d;
  logic              done_q,     done_d;
  logic              nack_q,     nack_d;
  logic [DATA_W-1:0] rdata_q,    rdata_d;
  logic [LEN_W-1:0]  byte_cnt_q, byte_cnt_d;

  // ---------------------------------------------------------------------------
  // Helper terms
  // ---------------------------------------------------------------------------
  logic              w_len_ok;
  logic              w_last;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic [POS_W-1:0]  w_pos;
  logic [POS_W-1:0]  w_nxt_pos;
  logic              w_wr_bit;
  logic              w_wr_next_msb;
  logic [DATA_W-1:0] w_rd_word;

  assign w_len_ok  = (len != '0) && (len <= MAX_LEN);
  assign w_last    = (idx_q == (len_q - 1'b1));
  assign w_idx_nxt = idx_q + 1'b1;

  // {byte index, bit index} is exactly the flat bit position 8*idx+bit,
  // so the byte arrays can be addressed by shifting a one-hot mask instead
  // of a variable bit-select.
  assign w_pos     = {idx_q, bit_q};
  assign w_nxt_pos = {w_idx_nxt, 3'd7};

  assign w_wr_bit      = |(wdata_q & (DATA_ONE << w_pos));
  assign w_wr_next_msb = |(wdata_q & (DATA_ONE << w_nxt_pos));

  // Current rdata with the bit at the active position replaced by SDA_in.
  assign w_rd_word = (rdata_q & ~(DATA_ONE << w_pos))
                   | ({{(DATA_W-1){1'b0}}, SDA_in} << w_pos);

  // ---------------------------------------------------------------------------
  // Transfer FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    wdata_d    = wdata_q;
    idx_d      = idx_q;
    bit_d      = bit_q;
    sda_d      = sda_q;
    done_d     = 1'b0;
    nack_d     = nack_q;
    rdata_d    = rdata_q;
    byte_cnt_d = byte_cnt_q;

    case (state_q)
      ST_IDLE: begin
        sda_d = 1'b1;
        if (start && w_len_ok) begin
          addr_d     = {address, rw};
          len_d      = len;
          wdata_d    = wdata;
          nack_d     = 1'b0;
          byte_cnt_d = '0;
          idx_d      = '0;
          state_d    = ST_START;
        end
      end

      ST_START: begin
        sda_d   = 1'b0;
        bit_d   = 3'd7;
        state_d = ST_ADDRESS;
      end

      ST_ADDRESS: begin
        sda_d = addr_q[bit_q];
        bit_d = bit_q - 1'b1;
        if (bit_q == 3'd0) begin
          state_d = ST_ADDR_ACK;
        end
      end

      ST_ADDR_ACK: begin
        sda_d   = 1'b1;
        state_d = ST_ADDR_CHK;
      end

      ST_ADDR_CHK: begin
        if (SDA_in) begin
          // Address not acknowledged: pull SDA low so STOP is a clean rise.
          nack_d  = 1'b1;
          sda_d   = 1'b0;
          state_d = ST_STOP;
        end else if (!addr_q[0]) begin
          // MSB of byte 0 goes out on this edge, the rest from bit 6 down.
          sda_d   = wdata_q[7];
          bit_d   = 3'd6;
          state_d = ST_WRITE_DATA;
        end else begin
          sda_d   = 1'b1;
          bit_d   = 3'd7;
          state_d = ST_READ_DATA;
        end
      end

      ST_WRITE_DATA: begin
        sda_d = w_wr_bit;
        bit_d = bit_q - 1'b1;
        if (bit_q == 3'd0) begin
          state_d = ST_WR_ACK;
        end
      end

      ST_WR_ACK: begin
        sda_d   = 1'b1;
        state_d = ST_WR_CHK;
      end

      ST_WR_CHK: begin
        if (SDA_in) begin
          nack_d  = 1'b1;
          sda_d   = 1'b0;
          state_d = ST_STOP;
        end else begin
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (w_last) begin
            sda_d   = 1'b0;
            state_d = ST_STOP;
          end else begin
            idx_d   = w_idx_nxt;
            sda_d   = w_wr_next_msb;
            bit_d   = 3'd6;
            state_d = ST_WRITE_DATA;
          end
        end
      end

      ST_READ_DATA: begin
        rdata_d = w_rd_word;
        sda_d   = 1'b1;
        bit_d   = bit_q - 1'b1;
        if (bit_q == 3'd0) begin
          // Master NACKs the final byte, ACKs every earlier one.
          sda_d      = w_last;
          byte_cnt_d = byte_cnt_q + 1'b1;
          state_d    = ST_RD_ACK;
        end
      end

      ST_RD_ACK: begin
        if (w_last) begin
          sda_d   = 1'b0;
          state_d = ST_STOP;
        end else begin
          sda_d   = 1'b1;
          idx_d   = w_idx_nxt;
          bit_d   = 3'd7;
          state_d = ST_READ_DATA;
        end
      end

      ST_STOP: begin
        sda_d   = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        sda_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Reset aborts immediately with SDA released; no STOP sequence is emitted.
  always_ff @(negedge i2c_scl_in) begin
    if (!resetN) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      len_q      <= '0;
      wdata_q    <= '0;
      idx_q      <= '0;
      bit_q      <= '0;
      sda_q      <= 1'b1;
      done_q     <= 1'b0;
      nack_q     <= 1'b0;
      rdata_q    <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      wdata_q    <= wdata_d;
      idx_q      <= idx_d;
      bit_q      <= bit_d;
      sda_q      <= sda_d;
      done_q     <= done_d;
      nack_q     <= nack_d;
      rdata_q    <= rdata_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign SDA_out    = sda_q;
  assign busy       = (state_q != ST_IDLE);
  assign i2c_scl_en = busy;
  assign done       = done_q;
  assign nack       = nack_q;
  assign rdata      = rdata_q;
  assign byte_cnt   = byte_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_burst_datapath.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_i2c_master_burst_datapath                               |
// | Description : Scoreboard bench for i2c_master_burst_datapath. Stimulus   |
// |               queues expected results; a monitor captures the SDA bit    |
// |               stream and status at each done pulse and compares.         |
// | Revision    : 1.0  initial                                               |
// +--------------------------------------------------------------------------+
module tb_i2c_master_burst_datapath;

  localparam int MAXB = 4;
  localparam int LW   = 3;

  logic            clk = 1'b0;
  logic            resetN;
  logic            start;
  logic            rw;
  logic [6:0]      address;
  logic [LW-1:0]   len;
  logic [8*MAXB-1:0] wdata;
  logic            SDA_in;
  logic            SDA_out;
  logic            i2c_scl_en;
  logic            busy;
  logic            done;
  logic            nack;
  logic [8*MAXB-1:0] rdata;
  logic [LW-1:0]   byte_cnt;

  i2c_master_burst_datapath #(.MAX_BYTES(MAXB)) dut (
    .i2c_scl_in (clk),
    .resetN     (resetN),
    .start      (start),
    .rw         (rw),
    .address    (address),
    .len        (len),
    .wdata      (wdata),
    .SDA_in     (SDA_in),
    .SDA_out    (SDA_out),
    .i2c_scl_en (i2c_scl_en),
    .busy       (busy),
    .done       (done),
    .nack       (nack),
    .rdata      (rdata),
    .byte_cnt   (byte_cnt)
  );

  // DUT acts on negedge; the bench drives and samples on posedge.
  always #5 clk = ~clk;

  typedef struct {
    int          lat;
    logic [63:0] seq;
    logic        nk;
    logic [2:0]  bc;
    logic [31:0] rd;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Slave configuration for the running transaction
  logic        sl_rw  = 1'b0;
  logic [31:0] sl_rb  = '0;
  int          sl_nst = -1;   // -1 none, 0 address NACK, j+1 NACK data byte j

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic [63:0] ap(input logic [63:0] s, input logic b);
    return {s[62:0], b};
  endfunction

  // Expected SDA_out value after every edge from the one following accept
  // up to and including the done edge.
  function automatic logic [63:0] mk_seq(input logic r, input logic [6:0] a, input int n,
                                         input logic [31:0] wd, input int nst);
    logic [63:0] s;
    logic [7:0]  ab;
    logic [31:0] t;
    logic [7:0]  bt;
    s  = '0;
    ab = {a, r};
    s  = ap(s, 1'b0);
    for (int i = 7; i >= 0; i--) s = ap(s, ab[i]);
    s = ap(s, 1'b1);
    if (nst == 0) begin
      s = ap(s, 1'b0);
      s = ap(s, 1'b1);
      return s;
    end
    if (!r) begin
      for (int j = 0; j < n; j++) begin
        t  = wd >> (8 * j);
        bt = t[7:0];
        for (int i = 7; i >= 0; i--) s = ap(s, bt[i]);
        s = ap(s, 1'b1);
        if (nst == j + 1 || j == n - 1) begin
          s = ap(s, 1'b0);
          s = ap(s, 1'b1);
          return s;
        end
      end
    end else begin
      s = ap(s, 1'b1);
      for (int j = 0; j < n; j++) begin
        for (int i = 0; i < 7; i++) s = ap(s, 1'b1);
        s = ap(s, (j == n - 1));
        if (j == n - 1) begin
          s = ap(s, 1'b0);
          s = ap(s, 1'b1);
        end else begin
          s = ap(s, 1'b1);
        end
      end
    end
    return s;
  endfunction

  // SDA_in the slave presents for edge e (edges counted from accept).
  function automatic logic slave_bit(input int e);
    logic [31:0] t;
    int off, j, p;
    if (e == 11) return (sl_nst == 0);
    if (!sl_rw) begin
      for (int k = 0; k < MAXB; k++)
        if (e == 20 + 9 * k) return (sl_nst == k + 1);
    end else if (e >= 12) begin
      off = e - 12;
      j   = off / 9;
      p   = off % 9;
      if (j < MAXB && p < 8) begin
        t = sl_rb >> (8 * j + 7 - p);
        return t[0];
      end
    end
    return 1'b1;
  endfunction

  // Slave model
  initial begin : slave
    bit act;
    int sc;
    act    = 0;
    sc     = 0;
    SDA_in = 1'b1;
    forever begin
      @(posedge clk);
      if (!act) begin
        if (busy === 1'b1) begin
          act = 1;
          sc  = 0;
        end
      end else if (busy !== 1'b1) begin
        act = 0;
      end else begin
        sc++;
      end
      SDA_in = act ? slave_bit(sc + 1) : 1'b1;
    end
  end

  // Monitor: capture each transaction and compare at its done pulse
  initial begin : monitor
    bit          act;
    bit          chk_low;
    int          cnt;
    logic [63:0] seq;
    exp_t        e;
    act     = 0;
    chk_low = 0;
    cnt     = 0;
    seq     = '0;
    forever begin
      @(posedge clk);
      if (chk_low) begin
        check("done_width", {63'd0, done}, 64'd0);
        chk_low = 0;
      end
      if (!act) begin
        if (busy === 1'b1) begin
          act = 1;
          cnt = 0;
          seq = '0;
        end
      end else begin
        cnt++;
        seq = ap(seq, SDA_out);
        if (done === 1'b1) begin
          act     = 0;
          chk_low = 1;
          if (sb_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
          end else begin
            e = sb_q.pop_front();
            check("latency",  64'(cnt),      64'(e.lat));
            check("sda_seq",  seq,           e.seq);
            check("nack",     {63'd0, nack}, {63'd0, e.nk});
            check("byte_cnt", 64'(byte_cnt), 64'(e.bc));
            check("rdata",    64'(rdata),    64'(e.rd));
          end
        end else if (busy !== 1'b1) begin
          act = 0;  // aborted by reset
        end
      end
    end
  end

  task automatic run_txn(input logic r, input logic [6:0] a, input int n, input logic [31:0] wd,
                         input logic [31:0] rb, input int nst, input int lat, input logic enk,
                         input logic [2:0] ebc, input logic [31:0] erd, input int pulse_at);
    exp_t e;
    bit   got;
    e.lat = lat;
    e.seq = mk_seq(r, a, n, wd, nst);
    e.nk  = enk;
    e.bc  = ebc;
    e.rd  = erd;
    sb_q.push_back(e);
    sl_rw  = r;
    sl_rb  = rb;
    sl_nst = nst;
    rw      = r;
    address = a;
    len     = LW'(n);
    wdata   = wd;
    start   = 1'b1;
    @(posedge clk);
    start = 1'b0;
    got   = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (done === 1'b1) begin
        got = 1;
        break;
      end
      if (i == pulse_at) begin
        // Ignored request with different contents while busy
        start   = 1'b1;
        rw      = ~r;
        address = 7'h7F;
        len     = 3'd1;
        wdata   = 32'h0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    if (!got) check("done_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge clk);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    bit ok;
    resetN  = 1'b0;
    start   = 1'b0;
    rw      = 1'b0;
    address = '0;
    len     = '0;
    wdata   = '0;
    repeat (3) @(posedge clk);
    check("rst_sda",      {63'd0, SDA_out}, 64'd1);
    check("rst_busy",     {63'd0, busy},    64'd0);
    check("rst_done",     {63'd0, done},    64'd0);
    check("rst_nack",     {63'd0, nack},    64'd0);
    check("rst_byte_cnt", 64'(byte_cnt),    64'd0);
    check("rst_rdata",    64'(rdata),       64'd0);
    check("rst_scl_en",   {63'd0, i2c_scl_en}, 64'd0);
    resetN = 1'b1;
    @(posedge clk);

    // Reset asserted mid-ADDRESS
    sl_rw = 1'b0; sl_nst = -1;
    rw = 1'b0; address = 7'h50; len = 3'd1; wdata = 32'h000000A5;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    check("midaddr_busy", {63'd0, busy}, 64'd1);
    resetN = 1'b0;
    repeat (2) @(posedge clk);
    check("mid_rst_sda",  {63'd0, SDA_out}, 64'd1);
    check("mid_rst_busy", {63'd0, busy},    64'd0);
    check("mid_rst_done", {63'd0, done},    64'd0);
    resetN = 1'b1;
    ok = 1;
    repeat (10) begin
      @(posedge clk);
      if (SDA_out !== 1'b1 || busy !== 1'b0) ok = 0;
    end
    check("post_rst_quiet", {63'd0, ok}, 64'd1);

    // Single write 0x50 / 0xA5
    run_txn(1'b0, 7'h50, 1, 32'h000000A5, 32'h0, -1, 21, 1'b0, 3'd1, 32'h00000000, -1);
    // Burst read 0x3C, 3 bytes 0x11 0x22 0x33
    run_txn(1'b1, 7'h3C, 3, 32'h0, 32'h00332211, -1, 39, 1'b0, 3'd3, 32'h00332211, -1);
    // Address NACK
    run_txn(1'b0, 7'h12, 2, 32'h0000BEEF, 32'h0, 0, 12, 1'b1, 3'd0, 32'h00332211, -1);
    // Data NACK on byte 1 of a 4-byte write
    run_txn(1'b0, 7'h2A, 4, 32'h44332211, 32'h0, 2, 30, 1'b1, 3'd1, 32'h00332211, -1);

    // len=0 and len>MAX_BYTES requests are ignored; nack stays set
    ok = 1;
    rw = 1'b0; address = 7'h10; wdata = 32'hFFFFFFFF;
    start = 1'b1; len = 3'd0;
    repeat (3) begin @(posedge clk); if (busy !== 1'b0) ok = 0; end
    len = 3'd5;
    repeat (3) begin @(posedge clk); if (busy !== 1'b0) ok = 0; end
    start = 1'b0;
    repeat (2) begin @(posedge clk); if (busy !== 1'b0) ok = 0; end
    check("bad_len_ignored", {63'd0, ok}, 64'd1);
    check("nack_held",       {63'd0, nack}, 64'd1);

    // Full-length write with a start pulse while busy; nack cleared on accept
    run_txn(1'b0, 7'h2A, 4, 32'hDEADBEEF, 32'h0, -1, 48, 1'b0, 3'd4, 32'h00332211, 15);
    // Short read: upper rdata bytes keep earlier values
    run_txn(1'b1, 7'h3C, 1, 32'h0, 32'h0000007E, -1, 21, 1'b0, 3'd1, 32'h0033227E, -1);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
